// File: rtl/nn_mul_acc_pipe.sv
// Pipelined multiply / multiply-accumulate with per-beat operand signedness,
// clock-enable stall, valid tracking and a sticky per-chain overflow flag.
module nn_mul_acc_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 9,
    parameter int din1_WIDTH = 12,
    parameter int dout_WIDTH = 24
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  din0_signed,
    input  logic                  din1_signed,
    input  logic                  acc_en,
    input  logic                  acc_first,
    output logic                  out_valid,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int W    = dout_WIDTH;
    localparam int PW   = din0_WIDTH + din1_WIDTH + 2;
    // Product is carried at least one bit wider than the result so the range checks always see a sign/carry bit.
    localparam int EW   = (PW > W) ? PW : W + 1;
    localparam int D    = NUM_STAGE - 2;
    localparam int DA   = (D > 0) ? D : 1;
    localparam int LAST = (D > 0) ? D - 1 : 0;

    if (NUM_STAGE < 2 || NUM_STAGE > 6 || dout_WIDTH < 2 || ID < 0) begin : g_bad_param
        $error("nn_mul_acc_pipe: illegal parameter set");
    end

    typedef struct packed {
        logic v;
        logic en;
        logic first;
        logic rs;
    } ctrl_t;

    logic signed [din0_WIDTH:0] a1;
    logic signed [din1_WIDTH:0] b1;
    ctrl_t                      c1;
    logic signed [EW-1:0]       prod0;
    logic signed [EW-1:0]       pp [DA];
    ctrl_t                      pc [DA];
    logic signed [EW-1:0]       pt;
    ctrl_t                      ct;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            a1 <= '0;
            b1 <= '0;
            c1 <= '0;
        end else if (ce) begin
            a1       <= {din0_signed & din0[din0_WIDTH-1], din0};
            b1       <= {din1_signed & din1[din1_WIDTH-1], din1};
            c1.v     <= in_valid;
            c1.en    <= acc_en;
            c1.first <= acc_first;
            c1.rs    <= din0_signed | din1_signed;
        end
    end

    assign prod0 = EW'(a1) * EW'(b1);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int unsigned i = 0; i < DA; i++) begin
                pp[i] <= '0;
                pc[i] <= '0;
            end
        end else if (ce) begin
            pp[0] <= prod0;
            pc[0] <= c1;
            for (int unsigned i = 1; i < DA; i++) begin
                pp[i] <= pp[i-1];
                pc[i] <= pc[i-1];
            end
        end
    end

    // With two stages the product feeds the output register directly.
    assign pt = (D > 0) ? pp[LAST] : prod0;
    assign ct = (D > 0) ? pc[LAST] : c1;

    logic [W-1:0] base, tp, nxt_dout;
    logic [W:0]   sum;
    logic         prod_ovf, add_ovf, nxt_ovf;

    always_comb begin
        base     = ct.first ? '0 : dout;
        tp       = pt[W-1:0];
        sum      = {ct.rs & base[W-1], base} + {ct.rs & tp[W-1], tp};
        add_ovf  = ct.rs ? (sum[W] ^ sum[W-1]) : sum[W];
        prod_ovf = ct.rs ? !((&pt[EW-1:W-1]) | ~(|pt[EW-1:W-1]))
                         : |pt[EW-1:W];
        nxt_dout = ct.en ? sum[W-1:0] : tp;
        nxt_ovf  = prod_ovf | (ct.en & add_ovf) | (ct.en & !ct.first & ovf);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            ovf       <= 1'b0;
        end else if (ce) begin
            out_valid <= ct.v;
            if (ct.v) begin
                dout <= nxt_dout;
                ovf  <= nxt_ovf;
            end
        end
    end

endmodule

// File: tb/tb_nn_mul_acc_pipe.sv
// Self-checking bench for nn_mul_acc_pipe: directed test-plan cases plus
// randomized beats against an arithmetic reference model.
module tb_nn_mul_acc_pipe;

    localparam int NS = 3;
    localparam int W0 = 9;
    localparam int W1 = 12;
    localparam int W  = 24;

    logic          ap_clk, ap_rst_n, ce, in_valid;
    logic [W0-1:0] din0;
    logic [W1-1:0] din1;
    logic          din0_signed, din1_signed, acc_en, acc_first;
    logic          out_valid, ovf;
    logic [W-1:0]  dout;

    nn_mul_acc_pipe #(
        .ID(1), .NUM_STAGE(NS), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(W)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .in_valid(in_valid),
        .din0(din0), .din1(din1), .din0_signed(din0_signed), .din1_signed(din1_signed),
        .acc_en(acc_en), .acc_first(acc_first),
        .out_valid(out_valid), .dout(dout), .ovf(ovf)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic          v;
        logic [W0-1:0] a;
        logic [W1-1:0] b;
        logic          sa, sb, en, first;
    } beat_t;

    beat_t        q[$];
    logic         exp_v, exp_ovf;
    logic [W-1:0] exp_dout;

    function automatic longint interp(input logic [W-1:0] bits, input logic rs);
        return (rs && bits[W-1]) ? longint'(bits) - (longint'(1) << W) : longint'(bits);
    endfunction

    task automatic model_reset();
        beat_t bub;
        bub = '{v: 1'b0, a: '0, b: '0, sa: 1'b0, sb: 1'b0, en: 1'b0, first: 1'b0};
        q.delete();
        repeat (NS - 1) q.push_back(bub);
        exp_v = 1'b0; exp_dout = '0; exp_ovf = 1'b0;
    endtask

    // Result of one beat leaving the pipeline, from the arithmetic rules.
    task automatic model_apply(input beat_t bt);
        longint a, b, p, lo, hi, base, s;
        logic   rs, povf, aovf;
        logic [W-1:0] tp;
        a = longint'(bt.a); if (bt.sa && bt.a[W0-1]) a -= (longint'(1) << W0);
        b = longint'(bt.b); if (bt.sb && bt.b[W1-1]) b -= (longint'(1) << W1);
        p  = a * b;
        rs = bt.sa | bt.sb;
        lo = rs ? -(longint'(1) << (W-1)) : 0;
        hi = rs ? (longint'(1) << (W-1)) - 1 : (longint'(1) << W) - 1;
        povf = (p < lo) || (p > hi);
        tp = p[W-1:0];
        if (bt.en) begin
            base = bt.first ? 0 : interp(exp_dout, rs);
            s    = base + interp(tp, rs);
            aovf = (s < lo) || (s > hi);
            exp_ovf  = povf | aovf | (!bt.first & exp_ovf);
            exp_dout = s[W-1:0];
        end else begin
            exp_ovf  = povf;
            exp_dout = tp;
        end
    endtask

    task automatic cycle(input logic c, input logic v, input logic [W0-1:0] a,
                         input logic [W1-1:0] b, input logic sa, input logic sb,
                         input logic en, input logic fi);
        beat_t bt, f;
        ce = c; in_valid = v; din0 = a; din1 = b;
        din0_signed = sa; din1_signed = sb; acc_en = en; acc_first = fi;
        if (ap_rst_n && c) begin
            bt = '{v: v, a: a, b: b, sa: sa, sb: sb, en: en, first: fi};
            q.push_back(bt);
            f = q.pop_front();
            exp_v = f.v;
            if (f.v) model_apply(f);
        end
        @(negedge ap_clk);
        chk("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
        chk("dout", {40'd0, dout}, {40'd0, exp_dout});
        chk("ovf", {63'd0, ovf}, {63'd0, exp_ovf});
    endtask

    task automatic bubble();
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        repeat (NS - 1) bubble();
    endtask

    logic [W0-1:0] ra;
    logic [W1-1:0] rb;

    initial begin
        ap_rst_n = 1'b0; ce = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0;
        din0_signed = 1'b0; din1_signed = 1'b0; acc_en = 1'b0; acc_first = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_dout", {40'd0, dout}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        @(negedge ap_clk);
        model_reset();
        ap_rst_n = 1'b1;

        // Unsigned plain multiply
        cycle(1, 1, 9'd511, 12'd4095, 0, 0, 0, 0);
        drain();
        chk("umul_valid", {63'd0, out_valid}, 64'd1);
        chk("umul_dout", {40'd0, dout}, 64'h1FEE01);
        chk("umul_ovf", {63'd0, ovf}, 64'd0);
        bubble();
        chk("umul_single", {63'd0, out_valid}, 64'd0);

        // Signedness modes
        cycle(1, 1, 9'h1FF, 12'h800, 1, 1, 0, 0);
        drain();
        chk("ss_dout", {40'd0, dout}, 64'd2048);
        chk("ss_ovf", {63'd0, ovf}, 64'd0);
        cycle(1, 1, 9'h1FF, 12'd4095, 1, 0, 0, 0);
        drain();
        chk("su_dout", {40'd0, dout}, 64'hFFF001);
        chk("su_ovf", {63'd0, ovf}, 64'd0);

        // Accumulate chain, back to back
        cycle(1, 1, 9'd10, 12'd20, 1, 1, 1, 1);
        cycle(1, 1, 9'd5, 12'hFFD, 1, 1, 1, 0);
        cycle(1, 1, 9'd7, 12'd7, 1, 1, 1, 0);
        chk("acc1", {40'd0, dout}, 64'd200);
        bubble();
        chk("acc2", {40'd0, dout}, 64'd185);
        bubble();
        chk("acc3", {40'd0, dout}, 64'd234);
        cycle(1, 1, 9'd2, 12'd2, 1, 1, 1, 1);
        drain();
        chk("acc_new", {40'd0, dout}, 64'd4);

        // Same chain with a 2-cycle stall and a bubble in the middle
        cycle(1, 1, 9'd10, 12'd20, 1, 1, 1, 1);
        cycle(0, 1, 9'd5, 12'hFFD, 1, 1, 1, 0);
        cycle(0, 1, 9'd5, 12'hFFD, 1, 1, 1, 0);
        cycle(1, 0, 9'd99, 12'd99, 1, 1, 1, 1);
        cycle(1, 1, 9'd5, 12'hFFD, 1, 1, 1, 0);
        cycle(1, 1, 9'd7, 12'd7, 1, 1, 1, 0);
        drain();
        chk("stall_acc3", {40'd0, dout}, 64'd234);

        // Overflow on the 17th chained beat
        for (int k = 1; k <= 17; k++)
            cycle(1, 1, 9'd255, 12'd2047, 1, 1, 1, (k == 1));
        bubble();
        chk("ovf16_dout", {40'd0, dout}, 64'd8351760);
        chk("ovf16_flag", {63'd0, ovf}, 64'd0);
        bubble();
        chk("ovf17_dout", {40'd0, dout}, 64'h876711);
        chk("ovf17_flag", {63'd0, ovf}, 64'd1);
        cycle(1, 1, 9'd2, 12'd2, 1, 1, 1, 1);
        drain();
        chk("ovf_clear", {63'd0, ovf}, 64'd0);

        // Reset between edges with beats in flight
        cycle(1, 1, 9'd3, 12'd3, 0, 0, 0, 0);
        cycle(1, 1, 9'd4, 12'd4, 0, 0, 1, 1);
        cycle(1, 1, 9'd5, 12'd5, 0, 0, 1, 0);
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_dout", {40'd0, dout}, 64'd0);
        chk("mid_rst_ovf", {63'd0, ovf}, 64'd0);
        @(negedge ap_clk);
        model_reset();
        ap_rst_n = 1'b1;
        bubble();
        bubble();
        bubble();
        cycle(1, 1, 9'd6, 12'd6, 0, 0, 1, 0);
        drain();
        chk("post_rst_dout", {40'd0, dout}, 64'd36);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 3))
                0: ra = '1;
                1: begin ra = '0; ra[W0-1] = 1'b1; end
                default: ra = W0'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: rb = '1;
                1: begin rb = '0; rb[W1-1] = 1'b1; end
                default: rb = W1'($urandom);
            endcase
            cycle(($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0), ra, rb,
                  1'($urandom), 1'($urandom), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 4) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
